// File: rtl/apb_master_arb.sv
// -----------------------------------------------------------------------------
// apb_master_arb
//   Round-robin arbiter in front of a single APB master port. N_REQ local
//   requesters issue single read/write commands over valid/ready. One command
//   is granted at a time and driven through APB SETUP/ACCESS. PREADY wait
//   states are supported, with an optional wait-state timeout. Completion is
//   returned to the granted requester as a one-cycle rsp_valid pulse.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  max ACCESS cycles with PREADY=0 before abort (0 = never abort)
//
// Ports
//   PCLK, PRESETn   clock, asynchronous active-low reset
//   req_valid       per-requester command pending
//   req_write       per-requester 1 = write, 0 = read
//   req_addr        packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata       packed write data, same packing
//   req_ready       one-hot accept pulse (combinational)
//   rsp_valid       one-hot completion pulse (registered)
//   rsp_rdata       read data, valid with rsp_valid (0 for writes/timeouts)
//   rsp_err         timeout flag, valid with rsp_valid
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY   APB master port
// -----------------------------------------------------------------------------
module apb_master_arb #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_W-1:0]       PADDR,
  output logic [DATA_W-1:0]       PWDATA,
  input  logic [DATA_W-1:0]       PRDATA,
  input  logic                    PREADY
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Counter must hold TIMEOUT itself without wrapping.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Wait count at the start of the last permitted ACCESS cycle.
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                grant_found;
  logic [GW-1:0]       grant_idx;
  logic [N_REQ-1:0]    ready_raw;

  // Rotating-priority search starting just after the last granted requester.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx  = (int'(last_grant_q) + k) % N_REQ;
      cand = idx[GW-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    ready_raw    = '0;

    case (state_q)
      ST_IDLE: begin
        // Requests are only looked at here; anything raised while busy
        // simply waits for the next IDLE cycle.
        if (grant_found) begin
          ready_raw[grant_idx] = 1'b1;
          last_grant_d         = grant_idx;
          pwrite_d             = req_write[grant_idx];
          paddr_d              = req_addr[grant_idx*ADDR_W +: ADDR_W];
          pwdata_d             = req_wdata[grant_idx*DATA_W +: DATA_W];
          wait_cnt_d           = '0;
          state_d              = ST_SETUP;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        // last_grant_q still names the requester that owns this transfer.
        if (PREADY) begin
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_rdata_d               = pwrite_q ? '0 : PRDATA;
          rsp_err_d                 = 1'b0;
          state_d                   = ST_IDLE;
        end else if (TIMEOUT != 0 && wait_cnt_q == WAIT_LAST) begin
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_rdata_d               = '0;
          rsp_err_d                 = 1'b1;
          state_d                   = ST_IDLE;
        end else if (wait_cnt_q != '1) begin
          // Saturate so an unbounded wait (TIMEOUT = 0) never wraps.
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GW'(N_REQ - 1);
      wait_cnt_q   <= '0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // The accept pulse is combinational, so it is gated by reset directly.
  assign req_ready = ready_raw & {N_REQ{PRESETn}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = (state_q != ST_IDLE);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule
